// File: rtl/debounce_pkg.sv
// Shared types and helpers for the button debouncer and related input
// conditioning blocks.
package debounce_pkg;

   typedef enum logic [1:0] {
      STABLE_LO = 2'b00,
      QUAL_HI   = 2'b01,
      STABLE_HI = 2'b11,
      QUAL_LO   = 2'b10
   } deb_state_t;

   // Width of a counter that has to hold values 0..n; never narrower than 1 bit.
   function automatic int cnt_w(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/sync_ff_chain.sv
// Multi-flop synchronizer for a single asynchronous input. The reset value
// is a port so that one chain can settle to either level out of reset.
module sync_ff_chain #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rstn,
   input  logic rst_val,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] stg;

   // Shift the raw input through the chain; the last stage is the safe copy.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stg <= {STAGES{rst_val}};
      end else begin
         stg <= {stg[STAGES-2:0], d};
      end
   end

   assign q = stg[STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Debouncer for a raw push-button/switch input. The input is synchronized,
// then a new level is only accepted after STABLE_CYCLES consecutive
// synchronized samples that differ from the current output.
//
//  state     | meaning
//  ----------|-----------------------------------------------------------
//  STABLE_LO | q = 0, waiting for a synchronized 1
//  QUAL_HI   | counting consecutive 1 samples; any 0 aborts back to STABLE_LO
//  STABLE_HI | q = 1, waiting for a synchronized 0
//  QUAL_LO   | counting consecutive 0 samples; any 1 aborts back to STABLE_HI
module button_debouncer
   import debounce_pkg::*;
#(
   parameter int   SYNC_STAGES   = 2,
   parameter int   STABLE_CYCLES = 1000,
   parameter logic RESET_LEVEL   = 1'b0
) (
   input  logic clk,
   input  logic rstn,
   input  logic d_raw,
   output logic q,
   output logic rise,
   output logic fall,
   output logic busy
);

   localparam int               CNT_W     = cnt_w(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(STABLE_CYCLES);
   localparam deb_state_t       RST_STATE = RESET_LEVEL ? STABLE_HI : STABLE_LO;

   logic             d_sync;
   deb_state_t       state;
   logic [CNT_W-1:0] cnt;

   sync_ff_chain #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk     (clk),
      .rstn    (rstn),
      .rst_val (RESET_LEVEL),
      .d       (d_raw),
      .q       (d_sync)
   );

   // Qualification FSM with registered level, edge pulses and busy flag.
   // The revert test comes before the terminal-count test so a bounce on
   // the would-be qualifying sample still aborts the transition.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= RST_STATE;
         cnt   <= '0;
         q     <= RESET_LEVEL;
         rise  <= 1'b0;
         fall  <= 1'b0;
         busy  <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         case (state)
            STABLE_LO: begin
               if (d_sync) begin
                  if (STABLE_CYCLES == 1) begin
                     state <= STABLE_HI;
                     q     <= 1'b1;
                     rise  <= 1'b1;
                     cnt   <= '0;
                     busy  <= 1'b0;
                  end else begin
                     state <= QUAL_HI;
                     cnt   <= CNT_ONE;
                     busy  <= 1'b1;
                  end
               end
            end
            QUAL_HI: begin
               if (!d_sync) begin
                  state <= STABLE_LO;
                  cnt   <= '0;
                  busy  <= 1'b0;
               end else if (cnt == CNT_LAST) begin
                  state <= STABLE_HI;
                  q     <= 1'b1;
                  rise  <= 1'b1;
                  cnt   <= '0;
                  busy  <= 1'b0;
               end else begin
                  if (cnt != CNT_MAX) begin
                     cnt <= cnt + CNT_ONE;
                  end
                  busy <= 1'b1;
               end
            end
            STABLE_HI: begin
               if (!d_sync) begin
                  if (STABLE_CYCLES == 1) begin
                     state <= STABLE_LO;
                     q     <= 1'b0;
                     fall  <= 1'b1;
                     cnt   <= '0;
                     busy  <= 1'b0;
                  end else begin
                     state <= QUAL_LO;
                     cnt   <= CNT_ONE;
                     busy  <= 1'b1;
                  end
               end
            end
            QUAL_LO: begin
               if (d_sync) begin
                  state <= STABLE_HI;
                  cnt   <= '0;
                  busy  <= 1'b0;
               end else if (cnt == CNT_LAST) begin
                  state <= STABLE_LO;
                  q     <= 1'b0;
                  fall  <= 1'b1;
                  cnt   <= '0;
                  busy  <= 1'b0;
               end else begin
                  if (cnt != CNT_MAX) begin
                     cnt <= cnt + CNT_ONE;
                  end
                  busy <= 1'b1;
               end
            end
            default: begin
               state <= RST_STATE;
               cnt   <= '0;
               q     <= RESET_LEVEL;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed + random bench for button_debouncer (SYNC_STAGES=2,
// STABLE_CYCLES=4). A behavioural run-length model predicts each cycle's
// outputs; predictions go through a scoreboard queue. A plain register
// stands in for the downstream d_flipflop.
module tb_button_debouncer;

   localparam int SYNC = 2;
   localparam int STAB = 4;

   logic tb_clk = 1'b0;
   logic rstn;
   logic d_raw;
   logic q, rise, fall, busy;
   logic ff_q;

   always #10 tb_clk = ~tb_clk;

   button_debouncer #(
      .SYNC_STAGES   (SYNC),
      .STABLE_CYCLES (STAB),
      .RESET_LEVEL   (1'b0)
   ) dut (
      .clk   (tb_clk),
      .rstn  (rstn),
      .d_raw (d_raw),
      .q     (q),
      .rise  (rise),
      .fall  (fall),
      .busy  (busy)
   );

   // Downstream flip-flop fed by the debounced level.
   always_ff @(posedge tb_clk or negedge rstn) begin
      if (!rstn) ff_q <= 1'b0;
      else       ff_q <= q;
   end

   typedef struct {
      bit q;
      bit rise;
      bit fall;
      bit busy;
      bit ff;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   bit ms [SYNC];
   bit mq;
   int run;

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0b expected=%0b t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs == exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < SYNC; i++) ms[i] = 1'b0;
      mq  = 1'b0;
      run = 0;
   endtask

   // One clock edge of the reference: the FSM sees the oldest sync stage.
   task automatic model_edge(input bit d, output exp_t e);
      bit fin;
      fin    = ms[SYNC-1];
      e.ff   = mq;
      for (int i = SYNC - 1; i > 0; i--) ms[i] = ms[i-1];
      ms[0]  = d;
      e.rise = 1'b0;
      e.fall = 1'b0;
      if (fin != mq) begin
         run++;
         if (run == STAB) begin
            mq     = ~mq;
            e.rise = mq;
            e.fall = ~mq;
            run    = 0;
         end
      end else begin
         run = 0;
      end
      e.q    = mq;
      e.busy = (run != 0);
   endtask

   task automatic step(input bit d, input bit rn);
      exp_t e, got;
      @(negedge tb_clk);
      d_raw = d;
      rstn  = rn;
      if (!rn) begin
         model_reset();
         e = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      end else begin
         model_edge(d, e);
      end
      sb.push_back(e);
      @(posedge tb_clk);
      #1;
      got = sb.pop_front();
      chk("q", q, got.q);
      chk("rise", rise, got.rise);
      chk("fall", fall, got.fall);
      chk("busy", busy, got.busy);
      chk("ff_q", ff_q, got.ff);
   endtask

   // Hold a level for n edges; report the first rise/fall index and busy count.
   task automatic run_level(input bit d, input int n, output int rise_at,
                            output int fall_at, output int busy_n);
      rise_at = -1;
      fall_at = -1;
      busy_n  = 0;
      for (int i = 0; i < n; i++) begin
         step(d, 1'b1);
         if (rise === 1'b1 && rise_at < 0) rise_at = i;
         if (fall === 1'b1 && fall_at < 0) fall_at = i;
         if (busy === 1'b1) busy_n++;
      end
   endtask

   initial begin
      int r_at, f_at, b_n;
      int rises, falls;
      bit lvl;
      int len;

      rstn  = 1'b0;
      d_raw = 1'b0;
      model_reset();
      #1;
      chk("rst_q", q, 1'b0);
      chk("rst_rise", rise, 1'b0);
      chk("rst_fall", fall, 1'b0);
      chk("rst_busy", busy, 1'b0);

      // Toggle d_raw while held in reset: outputs must stay at reset values.
      for (int i = 0; i < 4; i++) step(i[0], 1'b0);

      // Release with d_raw high: a normal transition, q rises 5 edges after E0.
      run_level(1'b1, 8, r_at, f_at, b_n);
      chk_int("rel_rise_edge", r_at, 5);
      chk_int("rel_no_fall", f_at, -1);
      chk_int("rel_busy_cycles", b_n, 3);

      // Clean 1->0.
      run_level(1'b0, 8, r_at, f_at, b_n);
      chk_int("fall_edge", f_at, 5);
      chk_int("fall_no_rise", r_at, -1);

      // Glitches of 1, 2 and 3 clocks must be rejected.
      rises = 0;
      for (int w = 1; w <= 3; w++) begin
         run_level(1'b1, w, r_at, f_at, b_n);
         if (r_at >= 0) rises++;
         run_level(1'b0, 6, r_at, f_at, b_n);
         if (r_at >= 0) rises++;
      end
      chk_int("glitch_rises", rises, 0);
      chk("glitch_q", q, 1'b0);

      // Clean 0->1.
      run_level(1'b1, 8, r_at, f_at, b_n);
      chk_int("clean_rise_edge", r_at, 5);
      chk_int("clean_busy_cycles", b_n, 3);
      run_level(1'b0, 8, r_at, f_at, b_n);
      chk_int("clean_fall_edge", f_at, 5);

      // Late revert: high 3, low 1, high 10; only the second run qualifies.
      rises = 0;
      run_level(1'b1, 3, r_at, f_at, b_n);
      if (r_at >= 0) rises++;
      run_level(1'b0, 1, r_at, f_at, b_n);
      if (r_at >= 0) rises++;
      run_level(1'b1, 10, r_at, f_at, b_n);
      chk_int("late_rise_edge", r_at, 5);
      rises++;
      chk_int("late_rise_count", rises, 1);

      // Start a 1->0 qualification, then reset between edges.
      run_level(1'b0, 3, r_at, f_at, b_n);
      chk("midq_busy", busy, 1'b1);
      #5;
      rstn = 1'b0;
      #1;
      chk("midq_q", q, 1'b0);
      chk("midq_busy_clr", busy, 1'b0);
      chk("midq_rise", rise, 1'b0);
      chk("midq_fall", fall, 1'b0);
      chk("midq_cnt", (dut.cnt == '0), 1'b1);
      model_reset();
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      rises = 0;
      falls = 0;
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b1);
         if (rise === 1'b1) rises++;
         if (fall === 1'b1) falls++;
      end
      chk_int("midq_rel_rises", rises, 0);
      chk_int("midq_rel_falls", falls, 0);

      // Random bouncing into the downstream flop.
      for (int it = 0; it < 100; it++) begin
         lvl = 1'($urandom_range(0, 1));
         len = int'($urandom_range(1, 7));
         run_level(lvl, len, r_at, f_at, b_n);
      end
      run_level(1'b0, 10, r_at, f_at, b_n);
      chk("final_q", q, 1'b0);
      chk_int("sb_empty", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
